// File: rtl/player_ctrl.sv
// Player ship controller: owns ship position, lives, level and fire requests; pauses on hit/clear/death/win.
// Latency: every output is registered, updated one clk_i cycle after the sampled input or event.
// Backpressure: none; shot_busy_i suppresses new shots, and paused states wait for a fire edge to resume.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   frame_i                        one-cycle pulse per video frame (movement / flash timebase)
//   move_left_i, move_right_i      debounced direction buttons (level)
//   shoot_i                        fire/resume button (level, edge-detected here)
//   shot_busy_i                    player bullet already in flight
//   hit_i, level_clear_i           player struck / all enemies destroyed
//   pos_left_o, pos_right_o        ship horizontal extent in pixels
//   lives_o, level_o               remaining lives, current level (1-based)
//   alive_o .. game_over_o         status flags and single-cycle pulses
//   state_o                        one-hot present state (debug)
//
// Optional feature: define PLAYER_BONUS_LIFE_EN to award a life when clearing an even level.

module player_ctrl #(
    parameter int screen_width_p = 640,
    parameter int ship_width_p   = 32,
    parameter int pos_width_p    = 10,
    parameter int step_p         = 2,
    parameter int init_lives_p   = 2,
    parameter int max_lives_p    = 3,
    parameter int levels_p       = 8,
    parameter int flash_frames_p = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               frame_i,
    input  logic                               move_left_i,
    input  logic                               move_right_i,
    input  logic                               shoot_i,
    input  logic                               shot_busy_i,
    input  logic                               hit_i,
    input  logic                               level_clear_i,
    output logic [pos_width_p-1:0]             pos_left_o,
    output logic [pos_width_p-1:0]             pos_right_o,
    output logic [$clog2(max_lives_p+1)-1:0]   lives_o,
    output logic [$clog2(levels_p+1)-1:0]      level_o,
    output logic                               alive_o,
    output logic                               paused_o,
    output logic                               flash_o,
    output logic                               shot_o,
    output logic                               level_beat_o,
    output logic                               game_won_o,
    output logic                               game_over_o,
    output logic [6:0]                         state_o
);

    localparam int LIVES_W = $clog2(max_lives_p + 1);
    localparam int LEVEL_W = $clog2(levels_p + 1);
    localparam int FLASH_W = (flash_frames_p > 1) ? $clog2(flash_frames_p) : 1;

    localparam logic [pos_width_p-1:0] POS_MAX  = pos_width_p'(screen_width_p - ship_width_p);
    localparam logic [pos_width_p-1:0] POS_CTR  = pos_width_p'((screen_width_p - ship_width_p) / 2);
    localparam logic [pos_width_p-1:0] STEP     = pos_width_p'(step_p);
    localparam logic [pos_width_p-1:0] SHIP_M1  = pos_width_p'(ship_width_p - 1);

    localparam logic [LIVES_W-1:0] INIT_LIVES = LIVES_W'(init_lives_p);
    localparam logic [LIVES_W-1:0] ONE_LIFE   = LIVES_W'(1);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(levels_p);
    localparam logic [LEVEL_W-1:0] FIRST_LVL  = LEVEL_W'(1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(flash_frames_p - 1);
`ifdef PLAYER_BONUS_LIFE_EN
    localparam logic [LIVES_W-1:0] MAX_LIVES  = LIVES_W'(max_lives_p);
`endif

    typedef enum logic [6:0] {
        S_IDLE     = 7'b0000001,
        S_LEFT     = 7'b0000010,
        S_RIGHT    = 7'b0000100,
        S_HIT      = 7'b0001000,
        S_LVL_DONE = 7'b0010000,
        S_DEAD     = 7'b0100000,
        S_WON      = 7'b1000000
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    state_t                 btn_state;
    logic                   shoot_q;
    logic                   fire_edge;
    logic                   active;
    logic                   recentre;
    logic [FLASH_W-1:0]     flash_cnt_q;
    logic [pos_width_p-1:0] pos_moved;
    logic [pos_width_p-1:0] pos_d;

    assign state_o = state_q;

    always_comb begin
        fire_edge = shoot_i & ~shoot_q;
        active    = (state_q == S_IDLE) || (state_q == S_LEFT) || (state_q == S_RIGHT);
    end

    // Exactly one button selects a direction; none or both means stand still.
    always_comb begin
        btn_state = S_IDLE;
        if (move_left_i && !move_right_i)
            btn_state = S_LEFT;
        else if (move_right_i && !move_left_i)
            btn_state = S_RIGHT;
    end

    // Next state: in play, a hit outranks a level clear, which outranks the buttons.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_LEFT, S_RIGHT: begin
                if (hit_i)
                    state_d = (lives_o > ONE_LIFE) ? S_HIT : S_DEAD;
                else if (level_clear_i)
                    state_d = (level_o == LAST_LEVEL) ? S_WON : S_LVL_DONE;
                else
                    state_d = btn_state;
            end
            S_HIT, S_LVL_DONE, S_DEAD: begin
                if (fire_edge)
                    state_d = S_IDLE;
            end
            S_WON:   state_d = S_WON;
            default: state_d = S_IDLE;
        endcase
    end

    // Movement follows the present state, so a frame tick that coincides with a
    // state change still moves according to the state being left.
    always_comb begin
        pos_moved = pos_left_o;
        if (frame_i && state_q == S_LEFT)
            pos_moved = (pos_left_o > STEP) ? (pos_left_o - STEP) : '0;
        else if (frame_i && state_q == S_RIGHT)
            pos_moved = ((POS_MAX - pos_left_o) <= STEP) ? POS_MAX : (pos_left_o + STEP);
    end

    // Recentring on level clear and on restart takes precedence over the tick.
    always_comb begin
        recentre = ((state_d == S_LVL_DONE) && (state_q != S_LVL_DONE)) ||
                   ((state_q == S_DEAD) && fire_edge);
        pos_d    = recentre ? POS_CTR : pos_moved;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            shoot_q      <= 1'b0;
            pos_left_o   <= POS_CTR;
            pos_right_o  <= POS_CTR + SHIP_M1;
            lives_o      <= INIT_LIVES;
            level_o      <= FIRST_LVL;
            flash_cnt_q  <= '0;
            flash_o      <= 1'b0;
            shot_o       <= 1'b0;
            level_beat_o <= 1'b0;
            alive_o      <= 1'b1;
            paused_o     <= 1'b0;
            game_won_o   <= 1'b0;
            game_over_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shoot_q     <= shoot_i;
            pos_left_o  <= pos_d;
            pos_right_o <= pos_d + SHIP_M1;

            // Paused states never fire, so the resuming edge cannot launch a shot.
            shot_o       <= active & fire_edge & ~shot_busy_i;
            // A simultaneous hit swallows the clear; upstream re-asserts it later.
            level_beat_o <= active & ~hit_i & level_clear_i;

            alive_o     <= (state_d != S_DEAD);
            paused_o    <= (state_d == S_HIT) || (state_d == S_LVL_DONE) ||
                           (state_d == S_DEAD) || (state_d == S_WON);
            game_over_o <= (state_d == S_DEAD);
            game_won_o  <= (state_d == S_WON);

            if (active && hit_i) begin
                lives_o <= (lives_o > ONE_LIFE) ? (lives_o - 1'b1) : '0;
            end else if (active && level_clear_i && (level_o != LAST_LEVEL)) begin
                level_o <= level_o + 1'b1;
`ifdef PLAYER_BONUS_LIFE_EN
                // Bonus judged on the level just cleared, before the increment.
                if (!level_o[0] && (lives_o < MAX_LIVES))
                    lives_o <= lives_o + 1'b1;
`endif
            end

            if ((state_q == S_DEAD) && fire_edge) begin
                lives_o <= INIT_LIVES;
                level_o <= FIRST_LVL;
            end

            // Flash only runs while in HIT; leaving HIT by any path clears it.
            if (state_q == S_HIT && !fire_edge) begin
                if (frame_i) begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_q <= '0;
                        flash_o     <= ~flash_o;
                    end else begin
                        flash_cnt_q <= flash_cnt_q + 1'b1;
                    end
                end
            end else begin
                flash_cnt_q <= '0;
                flash_o     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Each scenario task drives its stimulus and compares against hand-computed values.

module tb_player_ctrl;

    localparam logic [6:0] ST_IDLE  = 7'h01;
    localparam logic [6:0] ST_LEFT  = 7'h02;
    localparam logic [6:0] ST_RIGHT = 7'h04;
    localparam logic [6:0] ST_HIT   = 7'h08;
    localparam logic [6:0] ST_LVL   = 7'h10;
    localparam logic [6:0] ST_DEAD  = 7'h20;
    localparam logic [6:0] ST_WON   = 7'h40;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       frame_i = 1'b0;
    logic       move_left_i = 1'b0;
    logic       move_right_i = 1'b0;
    logic       shoot_i = 1'b0;
    logic       shot_busy_i = 1'b0;
    logic       hit_i = 1'b0;
    logic       level_clear_i = 1'b0;
    logic [9:0] pos_left_o;
    logic [9:0] pos_right_o;
    logic [1:0] lives_o;
    logic [3:0] level_o;
    logic       alive_o;
    logic       paused_o;
    logic       flash_o;
    logic       shot_o;
    logic       level_beat_o;
    logic       game_won_o;
    logic       game_over_o;
    logic [6:0] state_o;

    int total = 0;
    int bad   = 0;

    player_ctrl dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .frame_i       (frame_i),
        .move_left_i   (move_left_i),
        .move_right_i  (move_right_i),
        .shoot_i       (shoot_i),
        .shot_busy_i   (shot_busy_i),
        .hit_i         (hit_i),
        .level_clear_i (level_clear_i),
        .pos_left_o    (pos_left_o),
        .pos_right_o   (pos_right_o),
        .lives_o       (lives_o),
        .level_o       (level_o),
        .alive_o       (alive_o),
        .paused_o      (paused_o),
        .flash_o       (flash_o),
        .shot_o        (shot_o),
        .level_beat_o  (level_beat_o),
        .game_won_o    (game_won_o),
        .game_over_o   (game_over_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
    endtask

    // Press and release the fire button (two cycles).
    task automatic fire();
        shoot_i = 1'b1;
        step();
        shoot_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%h exp=%h", state_o, ST_IDLE); end
        total++; if (pos_left_o !== 10'd304) begin bad++; $display("FAIL reset_pos_left got=%0d exp=304", pos_left_o); end
        total++; if (pos_right_o !== 10'd335) begin bad++; $display("FAIL reset_pos_right got=%0d exp=335", pos_right_o); end
        total++; if (lives_o !== 2'd2) begin bad++; $display("FAIL reset_lives got=%0d exp=2", lives_o); end
        total++; if (level_o !== 4'd1) begin bad++; $display("FAIL reset_level got=%0d exp=1", level_o); end
        total++; if ({alive_o, paused_o, flash_o, shot_o, level_beat_o, game_won_o, game_over_o} !== 7'b1000000) begin
            bad++; $display("FAIL reset_flags got=%b exp=1000000",
                {alive_o, paused_o, flash_o, shot_o, level_beat_o, game_won_o, game_over_o});
        end
    endtask

    task automatic test_move();
        int exp_pos;
        move_right_i = 1'b1;
        step();
        total++; if (state_o !== ST_RIGHT) begin bad++; $display("FAIL move_right_state got=%h exp=%h", state_o, ST_RIGHT); end
        total++; if (pos_left_o !== 10'd304) begin bad++; $display("FAIL move_no_frame got=%0d exp=304", pos_left_o); end
        exp_pos = 304;
        for (int i = 0; i < 200; i++) begin
            frame_i = 1'b1;
            step();
            frame_i = 1'b0;
            exp_pos = (exp_pos + 2 > 608) ? 608 : exp_pos + 2;
            total++; if (pos_left_o !== 10'(exp_pos)) begin bad++; $display("FAIL move_right_pos frame=%0d got=%0d exp=%0d", i, pos_left_o, exp_pos); end
            step();
        end
        total++; if (pos_right_o !== 10'd639) begin bad++; $display("FAIL move_right_edge got=%0d exp=639", pos_right_o); end

        move_right_i = 1'b0;
        move_left_i  = 1'b1;
        step();
        total++; if (state_o !== ST_LEFT) begin bad++; $display("FAIL move_left_state got=%h exp=%h", state_o, ST_LEFT); end
        for (int i = 0; i < 310; i++) begin
            frame_i = 1'b1;
            step();
            frame_i = 1'b0;
            exp_pos = (exp_pos < 2) ? 0 : exp_pos - 2;
            total++; if (pos_left_o !== 10'(exp_pos)) begin bad++; $display("FAIL move_left_pos frame=%0d got=%0d exp=%0d", i, pos_left_o, exp_pos); end
        end
        total++; if (pos_left_o !== 10'd0) begin bad++; $display("FAIL move_left_edge got=%0d exp=0", pos_left_o); end

        move_right_i = 1'b1;
        step();
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL both_buttons_state got=%h exp=%h", state_o, ST_IDLE); end
        frame_i = 1'b1;
        step();
        frame_i = 1'b0;
        total++; if (pos_left_o !== 10'd0) begin bad++; $display("FAIL idle_no_move got=%0d exp=0", pos_left_o); end
        move_left_i  = 1'b0;
        move_right_i = 1'b0;
        step();
    endtask

    task automatic test_shot();
        shoot_i = 1'b1;
        step();
        total++; if (shot_o !== 1'b1) begin bad++; $display("FAIL shot_pulse got=%b exp=1", shot_o); end
        step();
        total++; if (shot_o !== 1'b0) begin bad++; $display("FAIL shot_single got=%b exp=0", shot_o); end
        shoot_i = 1'b0;
        step();
        shot_busy_i = 1'b1;
        shoot_i = 1'b1;
        step();
        total++; if (shot_o !== 1'b0) begin bad++; $display("FAIL shot_busy got=%b exp=0", shot_o); end
        step();
        total++; if (shot_o !== 1'b0) begin bad++; $display("FAIL shot_busy_hold got=%b exp=0", shot_o); end
        shoot_i = 1'b0;
        shot_busy_i = 1'b0;
        step();
    endtask

    task automatic test_hit();
        hit_i = 1'b1;
        step();
        hit_i = 1'b0;
        total++; if (state_o !== ST_HIT) begin bad++; $display("FAIL hit1_state got=%h exp=%h", state_o, ST_HIT); end
        total++; if (lives_o !== 2'd1) begin bad++; $display("FAIL hit1_lives got=%0d exp=1", lives_o); end
        total++; if (paused_o !== 1'b1) begin bad++; $display("FAIL hit1_paused got=%b exp=1", paused_o); end
        for (int f = 1; f <= 16; f++) begin
            frame_i = 1'b1;
            step();
            frame_i = 1'b0;
            total++;
            if (flash_o !== (((f / 8) % 2) == 1)) begin
                bad++; $display("FAIL hit_flash frame=%0d got=%b exp=%b", f, flash_o, ((f / 8) % 2) == 1);
            end
        end
        hit_i = 1'b1;
        step();
        hit_i = 1'b0;
        total++; if (lives_o !== 2'd1 || state_o !== ST_HIT) begin bad++; $display("FAIL hit_ignored lives=%0d state=%h exp lives=1 state=%h", lives_o, state_o, ST_HIT); end
        shoot_i = 1'b1;
        step();
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL hit_resume_state got=%h exp=%h", state_o, ST_IDLE); end
        total++; if (shot_o !== 1'b0) begin bad++; $display("FAIL hit_resume_shot got=%b exp=0", shot_o); end
        total++; if (flash_o !== 1'b0) begin bad++; $display("FAIL hit_resume_flash got=%b exp=0", flash_o); end
        shoot_i = 1'b0;
        step();

        hit_i = 1'b1;
        step();
        hit_i = 1'b0;
        total++; if (state_o !== ST_DEAD) begin bad++; $display("FAIL hit2_state got=%h exp=%h", state_o, ST_DEAD); end
        total++; if (lives_o !== 2'd0) begin bad++; $display("FAIL hit2_lives got=%0d exp=0", lives_o); end
        total++; if (alive_o !== 1'b0 || game_over_o !== 1'b1) begin bad++; $display("FAIL hit2_flags alive=%b over=%b exp alive=0 over=1", alive_o, game_over_o); end
        shoot_i = 1'b1;
        step();
        shoot_i = 1'b0;
        total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL dead_restart_state got=%h exp=%h", state_o, ST_IDLE); end
        total++; if (lives_o !== 2'd2 || level_o !== 4'd1) begin bad++; $display("FAIL dead_restart lives=%0d level=%0d exp lives=2 level=1", lives_o, level_o); end
        total++; if (pos_left_o !== 10'd304) begin bad++; $display("FAIL dead_restart_pos got=%0d exp=304", pos_left_o); end
        total++; if (shot_o !== 1'b0 || alive_o !== 1'b1) begin bad++; $display("FAIL dead_restart_flags shot=%b alive=%b exp shot=0 alive=1", shot_o, alive_o); end
        step();
    endtask

    task automatic test_hit_and_clear();
        do_reset();
        hit_i = 1'b1;
        level_clear_i = 1'b1;
        step();
        hit_i = 1'b0;
        level_clear_i = 1'b0;
        total++; if (state_o !== ST_HIT) begin bad++; $display("FAIL hitclr_state got=%h exp=%h", state_o, ST_HIT); end
        total++; if (lives_o !== 2'd1 || level_o !== 4'd1) begin bad++; $display("FAIL hitclr lives=%0d level=%0d exp lives=1 level=1", lives_o, level_o); end
        total++; if (level_beat_o !== 1'b0) begin bad++; $display("FAIL hitclr_beat got=%b exp=0", level_beat_o); end
        fire();
    endtask

    task automatic test_bonus();
        do_reset();
        level_clear_i = 1'b1;
        step();
        level_clear_i = 1'b0;
        total++; if (state_o !== ST_LVL || level_o !== 4'd2) begin bad++; $display("FAIL clear1 state=%h level=%0d exp state=%h level=2", state_o, level_o, ST_LVL); end
        total++; if (level_beat_o !== 1'b1) begin bad++; $display("FAIL clear1_beat got=%b exp=1", level_beat_o); end
        total++; if (lives_o !== 2'd2) begin bad++; $display("FAIL clear1_lives got=%0d exp=2", lives_o); end
        step();
        total++; if (level_beat_o !== 1'b0) begin bad++; $display("FAIL clear1_beat_end got=%b exp=0", level_beat_o); end
        fire();
        move_right_i = 1'b1;
        step();
        frame_i = 1'b1;
        step();
        frame_i = 1'b0;
        total++; if (pos_left_o !== 10'd306) begin bad++; $display("FAIL bonus_move got=%0d exp=306", pos_left_o); end
        level_clear_i = 1'b1;
        step();
        level_clear_i = 1'b0;
        move_right_i = 1'b0;
        total++; if (level_o !== 4'd3) begin bad++; $display("FAIL clear2_level got=%0d exp=3", level_o); end
        total++; if (pos_left_o !== 10'd304) begin bad++; $display("FAIL clear2_recentre got=%0d exp=304", pos_left_o); end
`ifdef PLAYER_BONUS_LIFE_EN
        total++; if (lives_o !== 2'd3) begin bad++; $display("FAIL clear2_bonus got=%0d exp=3", lives_o); end
`else
        total++; if (lives_o !== 2'd2) begin bad++; $display("FAIL clear2_nobonus got=%0d exp=2", lives_o); end
`endif
        fire();
    endtask

    task automatic test_levels();
        do_reset();
        for (int lvl = 1; lvl < 8; lvl++) begin
            level_clear_i = 1'b1;
            step();
            level_clear_i = 1'b0;
            total++; if (state_o !== ST_LVL || level_o !== 4'(lvl + 1)) begin
                bad++; $display("FAIL levels_clear from=%0d state=%h level=%0d exp state=%h level=%0d", lvl, state_o, level_o, ST_LVL, lvl + 1);
            end
            fire();
            total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL levels_resume from=%0d got=%h exp=%h", lvl, state_o, ST_IDLE); end
        end
        level_clear_i = 1'b1;
        step();
        level_clear_i = 1'b0;
        total++; if (state_o !== ST_WON || game_won_o !== 1'b1) begin bad++; $display("FAIL won state=%h won=%b exp state=%h won=1", state_o, game_won_o, ST_WON); end
        total++; if (level_o !== 4'd8 || level_beat_o !== 1'b1) begin bad++; $display("FAIL won_level level=%0d beat=%b exp level=8 beat=1", level_o, level_beat_o); end
        fire();
        total++; if (state_o !== ST_WON || shot_o !== 1'b0) begin bad++; $display("FAIL won_sticky state=%h shot=%b exp state=%h shot=0", state_o, shot_o, ST_WON); end
        hit_i = 1'b1;
        step();
        hit_i = 1'b0;
        total++; if (state_o !== ST_WON) begin bad++; $display("FAIL won_hit got=%h exp=%h", state_o, ST_WON); end
        do_reset();
        total++; if (state_o !== ST_IDLE || game_won_o !== 1'b0 || level_o !== 4'd1) begin
            bad++; $display("FAIL won_reset state=%h won=%b level=%0d exp state=%h won=0 level=1", state_o, game_won_o, level_o, ST_IDLE);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_move();
        test_shot();
        test_hit();
        test_hit_and_clear();
        test_bonus();
        test_levels();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Parametrised player-ship controller for the space invaders core. It is a one-hot state machine that owns ship position, lives, level number and fire requests, and it pauses and resumes play on hit, level clear and game over. It sits between the debounced button inputs and the renderer/bullet logic. Screen, ship and lives geometry are generics, so the block serves any display mode.

## Interface
- screen_width_p, 640, visible pixels per line
- ship_width_p, 32, ship width in pixels
- pos_width_p, 10, width of position outputs
- step_p, 2, pixels moved per frame tick
- init_lives_p, 2, lives at reset and at restart
- max_lives_p, 3, lives ceiling
- levels_p, 8, levels to win the game
- flash_frames_p, 8, frames per flash_o half-period
- clk_i  in  1  clock; one clock, all state on its rising edge
- reset_i  in  1  reset; synchronous, active-high
- frame_i  in  1  one-cycle pulse per video frame
- move_left_i / move_right_i  in  1  debounced direction buttons (level)
- shoot_i  in  1  fire/resume button (level; edge-detected internally)
- shot_busy_i  in  1  player bullet already in flight
- hit_i  in  1  player struck this cycle
- level_clear_i  in  1  all enemies destroyed
- pos_left_o / pos_right_o  out  pos_width_p  ship left/right pixel (right = left + ship_width_p - 1)
- lives_o  out  $clog2(max_lives_p+1)  remaining lives
- level_o  out  $clog2(levels_p+1)  current level, 1-based
- alive_o, paused_o, flash_o, shot_o, level_beat_o, game_won_o, game_over_o  out  1  status
- state_o  out  7  one-hot present state (debug)

## Operation
- States: IDLE, LEFT, RIGHT (active); HIT, LVL_DONE, DEAD, WON (paused).
- Active-state next state uses this priority: hit_i > level_clear_i > buttons. Button decode: exactly one of left/right gives LEFT or RIGHT; none or both gives IDLE.
- Movement happens only on frame_i in LEFT/RIGHT. pos_left moves ±step_p and saturates at 0 and at screen_width_p − ship_width_p. There is no wrap.
- Fire edge = shoot_i & ~shoot_q. In an active state with ~shot_busy_i, the fire edge pulses shot_o for one cycle. A fire edge is ignored while busy.
- hit_i in an active state: if lives_o > 1, decrement lives and go to HIT. If lives_o == 1, set lives to 0 and go to DEAD.
- HIT: position held. flash_o toggles every flash_frames_p frame_i pulses. A fire edge returns to IDLE with flash_o = 0. hit_i is ignored.
- level_clear_i in an active state: if level_o == levels_p, go to WON. Otherwise go to LVL_DONE and increment level_o. level_beat_o pulses one cycle on entry to either state.
- LVL_DONE: position recentred. A fire edge goes to IDLE.
- DEAD: a fire edge restores init_lives_p, sets level to 1, recentres, and goes to IDLE.
- WON is sticky; only reset_i leaves it.
- Paused states produce no shot_o. The fire edge that resumes play does not also fire.
- alive_o = ~DEAD. paused_o = HIT|LVL_DONE|DEAD|WON. game_over_o = DEAD. game_won_o = WON.

## Timing
- All outputs are registered. Each state, position or counter update is visible the cycle after the sampled input.
- shot_o and level_beat_o are single-cycle pulses, one cycle after the causing edge or event.
- Reset values: state IDLE; pos_left (screen_width_p − ship_width_p)/2 (304 by default); lives init_lives_p; level 1; every 1-bit output 0 except alive_o = 1; shoot_q 0; flash counter 0.
- reset_i overrides everything, including mid-HIT and WON.
- hit_i and level_clear_i in the same cycle: the hit is taken and the clear is dropped. Upstream re-asserts level_clear_i after resume.
- frame_i coincident with a state change: movement uses the present state.

## Configuration
- PLAYER_BONUS_LIFE_EN defined: on entering LVL_DONE from an even level (before the increment), lives increment if lives_o < max_lives_p.
- PLAYER_BONUS_LIFE_EN undefined: lives never increase except at a DEAD restart. The bonus logic is absent.

## Test plan
- Reset, hold move_right_i for 200 frames -> pos_left_o steps +2 per frame from 304 and saturates at 608; pos_right_o = 639.
- Fire edge with shot_busy_i = 0, then with shot_busy_i = 1 -> exactly one shot_o pulse, one cycle after the first edge; none for the second.
- Two hit_i pulses with init_lives_p = 2 -> first: HIT, lives 1, flash_o toggles every 8 frames, fire edge resumes with no shot_o; second: DEAD, lives 0, alive_o = 0.
- hit_i and level_clear_i in the same cycle at lives 2 -> HIT, lives 1, level unchanged, no level_beat_o.
- Eight level_clear_i events, each resumed by a fire edge -> level_o goes 1→8, then WON with game_won_o = 1; a further fire edge leaves the state in WON.
- Clear level 2 at lives 2: with PLAYER_BONUS_LIFE_EN defined -> lives 3; undefined -> lives 2. In DEAD, a fire edge restores lives 2 and level 1.
